// File: rtl/vend_keypad_entry.sv
// Keypad entry controller: collects DIGITS key codes with backspace, enter, clear and
// inactivity timeout, then presents the finished code downstream over valid/ready.
module vend_keypad_entry #(
  parameter int DIGITS = 3,
  parameter int DIGIT_W = 4,
  parameter bit AUTO_SUBMIT = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter logic [DIGIT_W-1:0] CLEAR_CODE = 4'hF,
  parameter logic [DIGIT_W-1:0] BACK_CODE = 4'hE,
  parameter logic [DIGIT_W-1:0] ENTER_CODE = 4'hD,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      busy,
  input  logic                      clear,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_code,
  output logic                      code_valid,
  input  logic                      code_ready,
  output logic [DIGITS*DIGIT_W-1:0] code_out,
  output logic [CW-1:0]             digit_count,
  output logic                      timeout
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DIGITS - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, SUBMIT} state_t;
  state_t state;
  logic [TW-1:0] tmr;

  logic abort, back_key, enter_key, digit_key, in_entry, tmo_hit;
  assign abort     = clear || (key_valid && key_code == CLEAR_CODE);
  assign back_key  = key_valid && key_code == BACK_CODE;
  assign enter_key = key_valid && key_code == ENTER_CODE;
  assign digit_key = key_valid && key_code != CLEAR_CODE && key_code != BACK_CODE
                     && key_code != ENTER_CODE;
  assign in_entry  = (state == ENTRY) || (state == FULL);
  // A key on the same edge as expiry wins, so the timer only fires on a quiet cycle.
  assign tmo_hit   = (TIMEOUT_CYCLES > 0) && in_entry && !key_valid && tmr == TMR_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      code_out    <= '0;
      digit_count <= '0;
      code_valid  <= 1'b0;
      timeout     <= 1'b0;
      tmr         <= '0;
    end else begin
      timeout <= tmo_hit && !abort;
      if (TIMEOUT_CYCLES > 0 && in_entry && !key_valid) tmr <= tmr + 1'b1;
      else tmr <= '0;

      if (abort || tmo_hit) begin
        state       <= IDLE;
        code_out    <= '0;
        digit_count <= '0;
        code_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (digit_key && !busy) begin
              code_out[DIGIT_W-1:0] <= key_code;
              digit_count <= ONE;
              if (DIGITS == 1) begin
                state      <= AUTO_SUBMIT ? SUBMIT : FULL;
                code_valid <= AUTO_SUBMIT;
              end else begin
                state <= ENTRY;
              end
            end
          end
          ENTRY: begin
            if (digit_key) begin
              for (int i = 0; i < DIGITS; i++)
                if (digit_count == CW'(i)) code_out[i*DIGIT_W +: DIGIT_W] <= key_code;
              digit_count <= digit_count + 1'b1;
              if (digit_count == LAST_SLOT) begin
                state      <= AUTO_SUBMIT ? SUBMIT : FULL;
                code_valid <= AUTO_SUBMIT;
              end
            end else if (back_key) begin
              for (int i = 0; i < DIGITS; i++)
                if (digit_count == CW'(i + 1)) code_out[i*DIGIT_W +: DIGIT_W] <= '0;
              digit_count <= digit_count - 1'b1;
              if (digit_count == ONE) state <= IDLE;
            end
          end
          FULL: begin
            if (enter_key) begin
              state      <= SUBMIT;
              code_valid <= 1'b1;
            end else if (back_key) begin
              for (int i = 0; i < DIGITS; i++)
                if (digit_count == CW'(i + 1)) code_out[i*DIGIT_W +: DIGIT_W] <= '0;
              digit_count <= digit_count - 1'b1;
              state <= (digit_count == ONE) ? IDLE : ENTRY;
            end
          end
          SUBMIT: begin
            if (code_ready) begin
              state       <= IDLE;
              code_out    <= '0;
              digit_count <= '0;
              code_valid  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vend_keypad_entry.sv
// Bench for vend_keypad_entry: auto-submit instance with a 10-cycle timeout (table + sequences)
// and an enter-to-submit instance without timeout (hand sequence).
module tb_vend_keypad_entry;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DIGITS=3, AUTO_SUBMIT=1, TIMEOUT_CYCLES=10
  logic a_busy, a_clr, a_kv, a_rdy, a_cv, a_to;
  logic [3:0] a_kc;
  logic [11:0] a_out;
  logic [1:0] a_cnt;
  vend_keypad_entry #(.DIGITS(3), .DIGIT_W(4), .AUTO_SUBMIT(1'b1), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .reset(rst), .busy(a_busy), .clear(a_clr), .key_valid(a_kv), .key_code(a_kc),
    .code_valid(a_cv), .code_ready(a_rdy), .code_out(a_out), .digit_count(a_cnt), .timeout(a_to));

  // Instance B: DIGITS=3, AUTO_SUBMIT=0, no timeout
  logic b_busy, b_clr, b_kv, b_rdy, b_cv, b_to;
  logic [3:0] b_kc;
  logic [11:0] b_out;
  logic [1:0] b_cnt;
  vend_keypad_entry #(.DIGITS(3), .DIGIT_W(4), .AUTO_SUBMIT(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst), .busy(b_busy), .clear(b_clr), .key_valid(b_kv), .key_code(b_kc),
    .code_valid(b_cv), .code_ready(b_rdy), .code_out(b_out), .digit_count(b_cnt), .timeout(b_to));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic clr, bsy, kv;
    logic [3:0] kc;
    logic rdy;
    logic cv;
    logic [11:0] out;
    logic [1:0] cnt;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic clr, logic bsy, logic kv, logic [3:0] kc, logic rdy,
                              logic cv, logic [11:0] out, logic [1:0] cnt);
    vec_t v;
    v.clr = clr; v.bsy = bsy; v.kv = kv; v.kc = kc; v.rdy = rdy;
    v.cv = cv; v.out = out; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic cv, input logic [11:0] out,
                       input logic [1:0] cnt, input logic to);
    chk({name, ".code_valid"}, 32'(a_cv), 32'(cv));
    chk({name, ".code_out"}, 32'(a_out), 32'(out));
    chk({name, ".digit_count"}, 32'(a_cnt), 32'(cnt));
    chk({name, ".timeout"}, 32'(a_to), 32'(to));
  endtask

  task automatic chk_b(input string name, input logic cv, input logic [11:0] out,
                       input logic [1:0] cnt);
    chk({name, ".b_code_valid"}, 32'(b_cv), 32'(cv));
    chk({name, ".b_code_out"}, 32'(b_out), 32'(out));
    chk({name, ".b_digit_count"}, 32'(b_cnt), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_key(input logic [3:0] k);
    a_kv = 1'b1; a_kc = k;
    tick();
    a_kv = 1'b0;
  endtask

  task automatic b_key(input logic [3:0] k);
    b_kv = 1'b1; b_kc = k;
    tick();
    b_kv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_busy = 0; a_clr = 0; a_kv = 0; a_kc = 0; a_rdy = 0;
    b_busy = 0; b_clr = 0; b_kv = 0; b_kc = 0; b_rdy = 0;

    //           clr bsy kv kc    rdy  cv out      cnt
    vt.push_back(mk(0, 0, 1, 4'h1, 1, 0, 12'h001, 1));
    vt.push_back(mk(0, 0, 1, 4'h2, 1, 0, 12'h021, 2));
    vt.push_back(mk(0, 0, 1, 4'h3, 1, 1, 12'h321, 3));
    vt.push_back(mk(0, 0, 0, 4'h0, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h4, 0, 0, 12'h004, 1));
    vt.push_back(mk(0, 0, 1, 4'h5, 0, 0, 12'h054, 2));
    vt.push_back(mk(0, 0, 1, 4'hE, 0, 0, 12'h004, 1));
    vt.push_back(mk(0, 0, 1, 4'h6, 0, 0, 12'h064, 2));
    vt.push_back(mk(0, 0, 1, 4'h7, 0, 1, 12'h764, 3));
    for (int i = 0; i < 5; i++) vt.push_back(mk(0, 0, 0, 4'h0, 0, 1, 12'h764, 3));
    vt.push_back(mk(0, 0, 1, 4'h9, 0, 1, 12'h764, 3));
    vt.push_back(mk(0, 0, 0, 4'h0, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 1, 1, 4'h5, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h5, 1, 0, 12'h005, 1));
    vt.push_back(mk(0, 1, 1, 4'h6, 1, 0, 12'h065, 2));
    vt.push_back(mk(0, 0, 1, 4'hD, 1, 0, 12'h065, 2));
    vt.push_back(mk(1, 0, 0, 4'h0, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h8, 1, 0, 12'h008, 1));
    vt.push_back(mk(1, 0, 1, 4'hF, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'hE, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'hD, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'hF, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h1, 0, 0, 12'h001, 1));
    vt.push_back(mk(0, 0, 1, 4'h2, 0, 0, 12'h021, 2));
    vt.push_back(mk(0, 0, 1, 4'h3, 0, 1, 12'h321, 3));
    vt.push_back(mk(0, 0, 1, 4'hF, 0, 0, 12'h000, 0));
    vt.push_back(mk(1, 0, 1, 4'h4, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h7, 1, 0, 12'h007, 1));
    vt.push_back(mk(0, 0, 1, 4'hE, 1, 0, 12'h000, 0));
    vt.push_back(mk(0, 0, 1, 4'h2, 1, 0, 12'h002, 1));
    vt.push_back(mk(1, 0, 0, 4'h0, 1, 0, 12'h000, 0));

    tick(); tick();
    chk_a("reset", 0, 12'h000, 0, 0);
    chk_b("reset", 0, 12'h000, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      a_clr = vt[i].clr; a_busy = vt[i].bsy; a_kv = vt[i].kv; a_kc = vt[i].kc; a_rdy = vt[i].rdy;
      tick();
      chk_a($sformatf("vec[%0d]", i), vt[i].cv, vt[i].out, vt[i].cnt, 0);
    end
    a_clr = 0; a_busy = 0; a_kv = 0; a_kc = 0; a_rdy = 1;

    // Timeout fires on the 10th edge after the last key
    a_key(4'h2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_a($sformatf("tmo_wait%0d", k), 0, 12'h002, 1, 0);
    end
    tick();
    chk_a("tmo_pulse", 0, 12'h000, 0, 1);
    tick();
    chk_a("tmo_after", 0, 12'h000, 0, 0);

    // A key on the expiry edge wins and restarts the count
    a_key(4'h3);
    for (int k = 1; k <= 9; k++) tick();
    a_key(4'h4);
    chk_a("tmo_key_wins", 0, 12'h043, 2, 0);
    for (int k = 1; k <= 9; k++) tick();
    chk_a("tmo_restart_wait", 0, 12'h043, 2, 0);
    tick();
    chk_a("tmo_restart_pulse", 0, 12'h000, 0, 1);
    tick();

    // Asynchronous reset mid-entry, checked before any clock edge
    a_key(4'h1); a_key(4'h2);
    chk_a("pre_rst_entry", 0, 12'h021, 2, 0);
    rst = 1'b1; #1;
    chk_a("async_rst_entry", 0, 12'h000, 0, 0);
    #1 rst = 1'b0;
    a_key(4'h8);
    chk_a("post_rst_entry", 0, 12'h008, 1, 0);
    a_clr = 1; tick(); a_clr = 0;

    // Asynchronous reset mid-SUBMIT, then a fresh entry
    a_rdy = 0;
    a_key(4'h1); a_key(4'h2); a_key(4'h3);
    chk_a("pre_rst_submit", 1, 12'h321, 3, 0);
    rst = 1'b1; #1;
    chk_a("async_rst_submit", 0, 12'h000, 0, 0);
    #1 rst = 1'b0;
    a_rdy = 1;
    a_key(4'h5); a_key(4'h6); a_key(4'h7);
    chk_a("fresh_submit", 1, 12'h765, 3, 0);
    tick();
    chk_a("fresh_done", 0, 12'h000, 0, 0);

    // Enter-to-submit instance: FULL ignores digits, BACK reopens entry, ENTER submits
    b_key(4'h1); b_key(4'h2); b_key(4'h3);
    chk_b("b_full", 0, 12'h321, 3);
    b_key(4'h9);
    chk_b("b_full_ignore", 0, 12'h321, 3);
    b_key(4'hE);
    chk_b("b_back", 0, 12'h021, 2);
    b_key(4'hD);
    chk_b("b_enter_in_entry", 0, 12'h021, 2);
    b_key(4'h3);
    chk_b("b_refill", 0, 12'h321, 3);
    b_key(4'hD);
    chk_b("b_enter", 1, 12'h321, 3);
    tick(); tick();
    chk_b("b_hold", 1, 12'h321, 3);
    b_rdy = 1;
    tick();
    chk_b("b_accept", 0, 12'h000, 0);
    chk("b_timeout", 32'(b_to), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
